serial_tx_fifo: RTL and testbench

//  Buffered 8N1 UART transmitter: the transmit-side counterpart to the 9600-baud serial receiver on the 25 MHz domain.

---
 rtl/serial_tx_fifo_if.sv | 22 ++
 rtl/serial_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_serial_tx_fifo.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_fifo_if.sv
// Byte-push and status/line bundle between serial_ctrl (master) and the buffered UART transmitter (slave).
interface serial_tx_fifo_if #(
  parameter int FifoDepthLog2 = 4
);
  logic                     write_i;
  logic [7:0]               data_i;
  logic                     full_o;
  logic [FifoDepthLog2:0]   level_o;
  logic                     busy_o;
  logic                     overflow_o;
  logic                     txd_o;

  modport master (
    output write_i, data_i,
    input  full_o, level_o, busy_o, overflow_o, txd_o
  );

  modport slave (
    input  write_i, data_i,
    output full_o, level_o, busy_o, overflow_o, txd_o
  );
endinterface

// File: rtl/serial_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO feeds a start/data/stop serializer,
// back-to-back frames leave with no idle gap, and overflow is reported sticky.
module serial_tx_fifo #(
  parameter int ClkFrequency  = 25000000,
  parameter int Baud          = 9600,
  parameter int FifoDepthLog2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_tx_fifo_if.slave  bus
);

  localparam int Div   = (ClkFrequency + Baud / 2) / Baud;
  localparam int CntW  = (Div > 1) ? $clog2(Div) : 1;
  localparam int PtrW  = FifoDepthLog2;
  localparam int LvlW  = FifoDepthLog2 + 1;
  localparam int Depth = 1 << FifoDepthLog2;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [7:0]       mem_r [Depth];
  logic [PtrW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [LvlW-1:0]  level_r, level_nxt_s;
  logic [CntW-1:0]  cnt_r, cnt_nxt_s;
  logic [2:0]       bit_idx_r, bit_idx_nxt_s;
  logic [7:0]       shift_r, shift_nxt_s;
  logic             txd_r, txd_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             overflow_r;
  logic             bit_end_s, full_s, wr_acc_s, pop_s, fifo_nempty_s;

  assign bit_end_s     = (cnt_r == CntLast);
  assign full_s        = (level_r == LvlW'(Depth));
  assign fifo_nempty_s = (level_r != LvlW'(0));
  assign wr_acc_s      = bus.write_i & ~full_s;

  // Next-state, pop request and next line level for the serializer
  always_comb begin
    state_nxt_s   = state_r;
    pop_s         = 1'b0;
    cnt_nxt_s     = bit_end_s ? CntW'(0) : cnt_r + CntW'(1);
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CntW'(0);
        if (fifo_nempty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = mem_r[rd_ptr_r];
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = ST_DATA;
        end else begin
          state_nxt_s   = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_nxt_s   = {1'b0, shift_r[7:1]};
          bit_idx_nxt_s = bit_idx_r + 3'd1;
          state_nxt_s   = (bit_idx_r == 3'd7) ? ST_STOP : ST_DATA;
        end else begin
          state_nxt_s   = ST_DATA;
        end
      end
      ST_STOP: begin
        // A queued byte is reloaded straight into START so frames abut
        if (bit_end_s && fifo_nempty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = mem_r[rd_ptr_r];
          state_nxt_s = ST_START;
        end else if (bit_end_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    case (state_nxt_s)
      ST_START: txd_nxt_s = 1'b0;
      ST_DATA:  txd_nxt_s = shift_nxt_s[0];
      default:  txd_nxt_s = 1'b1;
    endcase

    case ({wr_acc_s, pop_s})
      2'b10:   level_nxt_s = level_r + LvlW'(1);
      2'b01:   level_nxt_s = level_r - LvlW'(1);
      default: level_nxt_s = level_r;
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE) | (level_nxt_s != LvlW'(0));
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; stale slots are harmless because reset clears the pointers
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= bus.data_i;
    end
  end

  // Pointers, occupancy, baud counter, shifter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= PtrW'(0);
      rd_ptr_r   <= PtrW'(0);
      level_r    <= LvlW'(0);
      cnt_r      <= CntW'(0);
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PtrW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrW'(1);
      end
      if (bus.write_i && full_s) begin
        overflow_r <= 1'b1;
      end
      level_r   <= level_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      txd_r     <= txd_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign bus.full_o     = full_s;
  assign bus.level_o    = level_r;
  assign bus.busy_o     = busy_r;
  assign bus.overflow_o = overflow_r;
  assign bus.txd_o      = txd_r;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Randomized bench for serial_tx_fifo: a queue-plus-frame-position model predicts
// every output on every cycle; directed phases cover reset, back-to-back, overflow and abort.
module tb_serial_tx_fifo;

  localparam int ClkFreq  = 16;
  localparam int BaudRate = 1;
  localparam int Fd       = 2;
  localparam int Depth    = 4;
  localparam int Div      = 16;
  localparam int FrameLen = 10 * Div;

  logic clk = 1'b0;
  logic rst_n;

  serial_tx_fifo_if #(.FifoDepthLog2(Fd)) bus ();

  serial_tx_fifo #(
    .ClkFrequency (ClkFreq),
    .Baud         (BaudRate),
    .FifoDepthLog2(Fd)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending bytes, sticky overflow, and the frame on the line
  logic [7:0] q [$];
  bit         m_ovf    = 1'b0;
  bit         m_active = 1'b0;
  logic [7:0] m_byte   = 8'd0;
  int         m_pos    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_pos / Div;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  task automatic model_edge(input logic wr, input logic [7:0] d, input logic rst);
    int occ;
    bit pop;
    if (!rst) begin
      q.delete();
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
      return;
    end
    occ = q.size();
    pop = 1'b0;
    if (!m_active) begin
      pop = (occ != 0);
    end else if (m_pos == FrameLen - 1) begin
      m_active = 1'b0;
      pop      = (occ != 0);
    end else begin
      m_pos++;
    end
    if (pop) begin
      m_byte   = q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end
    if (wr) begin
      if (occ == Depth) m_ovf = 1'b1;
      else q.push_back(d);
    end
  endtask

  task automatic step(input logic wr, input logic [7:0] d, input logic rst);
    bus.write_i = wr;
    bus.data_i  = d;
    rst_n       = rst;
    @(posedge clk);
    model_edge(wr, d, rst);
    @(negedge clk);
    check_eq("txd",      32'(bus.txd_o),      32'(exp_txd()));
    check_eq("level",    32'(bus.level_o),    32'(q.size()));
    check_eq("full",     32'(bus.full_o),     32'(q.size() == Depth));
    check_eq("busy",     32'(bus.busy_o),     32'(m_active || (q.size() != 0)));
    check_eq("overflow", 32'(bus.overflow_o), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    bit found;
    logic [7:0] tv [3];
    tv[0] = 8'hA3;
    tv[1] = 8'h0F;
    tv[2] = 8'hFF;
    bus.write_i = 1'b0;
    bus.data_i  = 8'h00;
    rst_n       = 1'b0;

    // Reset state
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("rst_txd",  32'(bus.txd_o),   32'd1);
    check_eq("rst_busy", 32'(bus.busy_o),  32'd0);
    check_eq("rst_lvl",  32'(bus.level_o), 32'd0);

    // Single byte, then three back-to-back frames
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check_eq("t2_start", 32'(bus.txd_o), 32'd0);
    idle(FrameLen + 20);
    check_eq("t2_busy", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, tv[i], 1'b1);
    idle(3 * FrameLen + 20);

    // Overflow: six consecutive writes, first byte popped at once
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'($urandom), 1'b1);
      if (i == 4) check_eq("t4_full", 32'(bus.full_o), 32'd1);
    end
    check_eq("t4_ovf", 32'(bus.overflow_o), 32'd1);
    idle(5 * FrameLen + 20);

    // Write coinciding with a pop at DEPTH-1 occupancy
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2 * FrameLen && !found; i++) begin
      if (m_active && m_pos == FrameLen - 1 && q.size() == 3) found = 1'b1;
      else step(1'b0, 8'h00, 1'b1);
    end
    check_eq("t5_reach", 32'(found), 32'd1);
    step(1'b1, 8'($urandom), 1'b1);
    check_eq("t5_level", 32'(bus.level_o),    32'd3);
    check_eq("t5_ovf",   32'(bus.overflow_o), 32'd0);
    idle(4 * FrameLen + 20);

    // Reset in the middle of the data bits of 0x81
    step(1'b1, 8'h81, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2 * FrameLen && !found; i++) begin
      if (m_active && m_pos == 3 * Div + 5) found = 1'b1;
      else step(1'b0, 8'h00, 1'b1);
    end
    check_eq("t6_reach", 32'(found), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check_eq("t6_txd",  32'(bus.txd_o),   32'd1);
    check_eq("t6_busy", 32'(bus.busy_o),  32'd0);
    check_eq("t6_lvl",  32'(bus.level_o), 32'd0);
    step(1'b1, 8'h3C, 1'b1);
    idle(FrameLen + 20);

    // Random traffic with occasional bursts
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        for (int j = 0; j < 5; j++) step(1'b1, 8'($urandom), 1'b1);
      end else begin
        step(($urandom_range(0, 29) == 0), 8'($urandom), 1'b1);
      end
    end
    idle(6 * FrameLen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
